// File: rtl/acc_ser.sv
// acc_ser: parallel-to-serial transmitter for the accumulator's serial load port.
// A word is captured on accept and its low L bits go out MSB-first, one bit per clock.
// tx_en frames the burst. After each complete burst there is one GAP cycle with
// done high, so the downstream accumulator can commit the frame.
//
// Ports:
//   clk    in          clock, rising edge
//   nRst   in          asynchronous active-low reset
//   start  in          transmit request, sampled in IDLE or GAP
//   len    in  [LENW]  bit count; 0 or anything above WIDTH means WIDTH
//   data   in  [WIDTH] word to send; bits [L-1:0] are transmitted
//   abort  in          truncates a burst in SHIFT
//   tx     out         serial bit, forced low outside tx_en
//   tx_en  out         frame strobe
//   busy   out         high in SHIFT and GAP
//   done   out         one-cycle pulse in GAP after a completed burst
module acc_ser #(
    parameter int WIDTH = 128,
    parameter int LENW  = 8
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             start,
    input  logic [LENW-1:0]  len,
    input  logic [WIDTH-1:0] data,
    input  logic             abort,
    output logic             tx,
    output logic             tx_en,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [LENW-1:0]  cnt_q, cnt_d;

    logic [LENW-1:0]  eff_len;
    logic [WIDTH-1:0] sh_load;

    // Clamp the length. 2^LENW > WIDTH, so WIDTH itself fits in the counter.
    always_comb begin
        eff_len = len;
        if (len == '0 || len > LENW'(WIDTH))
            eff_len = LENW'(WIDTH);
    end

    // Left-align the payload so bit L-1 lands on the MSB. The bits below are zero-filled.
    assign sh_load = data << (LENW'(WIDTH) - eff_len);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    sh_d    = sh_load;
                    cnt_d   = eff_len;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    sh_d    = '0;
                    cnt_d   = '0;
                end else begin
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q - LENW'(1);
                    if (cnt_q == LENW'(1))
                        state_d = GAP;
                end
            end
            GAP: begin
                // abort has no effect here; start may chain the next frame
                if (start) begin
                    state_d = SHIFT;
                    sh_d    = sh_load;
                    cnt_d   = eff_len;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                sh_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs decode registered state only, so there is no input-to-output path.
    assign tx_en = (state_q == SHIFT);
    assign tx    = tx_en & sh_q[WIDTH-1];
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == GAP);

endmodule

// File: tb/tb_acc_ser.sv
module tb_acc_ser;

    logic         clk = 1'b0;
    logic         nRst = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   len = '0;
    logic [127:0] data = '0;
    logic         abort = 1'b0;
    logic         tx, tx_en, busy, done;

    acc_ser #(.WIDTH(128), .LENW(8)) dut (
        .clk(clk), .nRst(nRst), .start(start), .len(len), .data(data),
        .abort(abort), .tx(tx), .tx_en(tx_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // scoreboard queues
    bit           exp_bits[$];
    logic [127:0] exp_fv[$];
    int           exp_fn[$];
    int           exp_done = 0;

    // monitor-side accumulator
    logic [127:0] acc = '0;
    int           nb = 0;
    logic [127:0] frame_sum = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Monitor: compares every presented bit, every completed frame and every done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_en) begin
                if (exp_bits.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_bit act=%0b exp=none", tx);
                end else begin
                    chk("tx_bit", {127'd0, tx}, {127'd0, exp_bits.pop_front()});
                end
                acc = {acc[126:0], tx};
                nb++;
            end else begin
                chk("tx_gated", {127'd0, tx}, 128'd0);
                if (nb > 0) begin
                    if (exp_fv.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_frame act=%0h exp=none", acc);
                    end else begin
                        chk("frame_val", acc, exp_fv.pop_front());
                        chk("frame_len", 128'(nb), 128'(exp_fn.pop_front()));
                    end
                    frame_sum = frame_sum + acc;
                    acc = '0;
                    nb  = 0;
                end
            end
            if (done) begin
                total++;
                if (exp_done == 0) begin
                    bad++;
                    $display("FAIL unexpected_done act=1 exp=0");
                end else begin
                    exp_done--;
                end
            end
        end
    end

    // Push the expected low L bits MSB-first, plus the frame and its done pulse.
    task automatic expect_burst(input logic [127:0] d, input int L);
        logic [127:0] m;
        for (int i = L - 1; i >= 0; i--) exp_bits.push_back(d[i]);
        m = (L >= 128) ? '1 : ((128'd1 << L) - 128'd1);
        exp_fv.push_back(d & m);
        exp_fn.push_back(L);
        exp_done++;
    endtask

    // Normal burst with timing checks. Called just after a rising edge.
    task automatic send(input logic [127:0] d, input logic [7:0] ln, input int L);
        expect_burst(d, L);
        start = 1'b1; data = d; len = ln;
        @(posedge clk); #1;
        start = 1'b0; data = '0; len = '0;
        chk("first_bit_latency", {127'd0, tx_en}, 128'd1);
        repeat (L) begin @(posedge clk); #1; end
        chk("gap_done", {126'd0, done, tx_en}, 128'b10);
        @(posedge clk); #1;
        chk("idle_after", {125'd0, busy, done, tx_en}, 128'd0);
    endtask

    initial begin
        logic [127:0] s0;
        logic [9:0]   pat;
        logic [4:0]   rbits;

        // reset with toggling inputs
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            start = 1'($urandom); abort = 1'($urandom);
            len = 8'($urandom); data = {4{$urandom}};
            @(negedge clk);
            chk("reset_outs", {124'd0, tx, tx_en, busy, done}, 128'd0);
        end
        start = 1'b0; abort = 1'b0; len = '0; data = '0;
        @(posedge clk); #1;
        nRst = 1'b1;
        chk("post_reset_idle", {127'd0, busy}, 128'd0);

        // basic 8-bit burst, accepted on the first edge after reset
        send(128'hA5, 8'd8, 8);

        // full width via len=0 and via clamp of len=255
        send({1'b1, 126'd0, 1'b1}, 8'd0, 128);
        send({1'b1, 126'd0, 1'b1}, 8'd255, 128);

        // back-to-back frames with an abort during GAP that must be ignored
        s0 = frame_sum;
        expect_burst(128'hF, 4);
        expect_burst(128'h3, 4);
        start = 1'b1; data = 128'hF; len = 8'd4;
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 0) data = 128'h3;
            if (i == 4) abort = 1'b1;
            if (i == 5) begin start = 1'b0; abort = 1'b0; end
            @(negedge clk);
            pat = {pat[8:0], tx_en};
        end
        chk("b2b_tx_en_pattern", {118'd0, pat}, 128'b1111011110);
        @(posedge clk); #1;
        chk("b2b_acc_sum", frame_sum - s0, 128'd18);
        @(posedge clk); #1;

        // abort at the 10th bit of a 33-bit burst; a mid-burst start is ignored
        for (int i = 32; i >= 23; i--) exp_bits.push_back(1'(33'h1_2345_6789 >> i));
        exp_fv.push_back(128'h246);
        exp_fn.push_back(10);
        start = 1'b1; data = 128'h1_2345_6789; len = 8'd33;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; data = '1; len = 8'd3;
        @(posedge clk); #1;
        start = 1'b0; data = '0; len = '0;
        repeat (4) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_outs", {125'd0, tx_en, busy, done}, 128'd0);
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_stays_idle", {127'd0, busy}, 128'd0);

        // async reset at bit 5 of 16'hBEEF, then a 2-bit burst
        rbits = 5'b10111;
        for (int i = 4; i >= 0; i--) exp_bits.push_back(rbits[i]);
        exp_fv.push_back(128'h17);
        exp_fn.push_back(5);
        start = 1'b1; data = 128'hBEEF; len = 8'd16;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk); #1;
        nRst = 1'b0;
        #1;
        chk("async_reset_outs", {124'd0, tx, tx_en, busy, done}, 128'd0);
        repeat (2) @(posedge clk);
        #1;
        nRst = 1'b1;
        send(128'h2, 8'd2, 2);

        repeat (4) begin @(posedge clk); #1; end
        chk("bits_left", 128'(exp_bits.size()), 128'd0);
        chk("frames_left", 128'(exp_fv.size()), 128'd0);
        chk("done_left", 128'(exp_done), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
